pluse_seq_ctrl: RTL and testbench

PLUSE_SEQ_CTRL -- requirements
Module: pluse_seq_ctrl

---
 rtl/pluse_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_pluse_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pluse_seq_ctrl.sv
// Sequencer that loads six parameter words into a pulse generator, then
// starts it repeatedly, with inter-train gaps, timeout and abort handling.
module pluse_seq_ctrl #(
    parameter int TO_SHIFT = 8
) (
    input  logic        clk_sys,
    input  logic        seqrst,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    input  logic        seq_go,
    input  logic        seq_abort,
    input  logic        pluseinter,
    output logic        pluseload,
    output logic        pluseloadchoice,
    output logic [15:0] plusedatain,
    output logic        plusestart,
    output logic        seq_busy,
    output logic        seq_done,
    output logic [15:0] rep_idx,
    output logic        err_timeout,
    output logic [2:0]  dbg_state
);

    localparam int CW = 16 + TO_SHIFT;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         state, state_nx;
    logic [15:0]    cfg [8];
    logic [2:0]     step, step_nx;
    logic [CW-1:0]  wcnt, wcnt_nx;
    logic [CW-1:0]  to_limit;
    logic [15:0]    rep_nx;
    logic [15:0]    eff_cnt;
    logic           err_nx;
    logic           inter_d;
    logic           inter_rise;

    assign dbg_state  = state;
    assign inter_rise = pluseinter & ~inter_d;
    assign to_limit   = CW'(cfg[7]) << TO_SHIFT;
    assign eff_cnt    = (cfg[6] == 16'd0) ? 16'd1 : cfg[6];

    always_ff @(posedge clk_sys or negedge seqrst) begin
        if (!seqrst) begin
            for (int i = 0; i < 8; i++) cfg[i] <= '0;
        end else if (cfg_we && state == S_IDLE) begin
            cfg[cfg_addr] <= cfg_data;
        end
    end

    // Handshake: seq_go is a single-cycle request honoured only in IDLE without
    // seq_abort; seq_abort is a level that returns any active state to IDLE.
    always_comb begin
        state_nx = state;
        step_nx  = step;
        wcnt_nx  = wcnt;
        rep_nx   = rep_idx;
        err_nx   = err_timeout;
        case (state)
            S_IDLE: begin
                if (seq_go && !seq_abort) begin
                    state_nx = S_LOAD;
                    step_nx  = 3'd0;
                    rep_nx   = 16'd0;
                    err_nx   = 1'b0;
                end
            end
            S_LOAD: begin
                if (step == 3'd5) state_nx = S_START;
                else              step_nx  = step + 3'd1;
            end
            S_START: begin
                wcnt_nx  = '0;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                // A train end seen in the same cycle as the timeout takes priority.
                if (inter_rise) begin
                    rep_nx   = rep_idx + 16'd1;
                    step_nx  = 3'd0;
                    state_nx = (rep_nx >= eff_cnt) ? S_DONE : S_GAP;
                end else begin
                    wcnt_nx = wcnt + CW'(1);
                    if (cfg[7] != 16'd0 && wcnt_nx == to_limit) begin
                        err_nx   = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (step == 3'd1) state_nx = S_START;
                else              step_nx  = step + 3'd1;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (seq_abort && state != S_IDLE) begin
            state_nx = S_IDLE;
            rep_nx   = rep_idx;
            err_nx   = err_timeout;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_sys or negedge seqrst) begin
        if (!seqrst) begin
            state           <= S_IDLE;
            step            <= '0;
            wcnt            <= '0;
            rep_idx         <= '0;
            err_timeout     <= 1'b0;
            inter_d         <= 1'b0;
            pluseload       <= 1'b0;
            pluseloadchoice <= 1'b0;
            plusedatain     <= '0;
            plusestart      <= 1'b0;
            seq_busy        <= 1'b0;
            seq_done        <= 1'b0;
        end else begin
            state           <= state_nx;
            step            <= step_nx;
            wcnt            <= wcnt_nx;
            rep_idx         <= rep_nx;
            err_timeout     <= err_nx;
            inter_d         <= pluseinter;
            pluseload       <= (state_nx == S_LOAD);
            pluseloadchoice <= (state_nx == S_LOAD) && (step_nx == 3'd0);
            plusedatain     <= (state_nx == S_LOAD) ? cfg[step_nx] : 16'd0;
            plusestart      <= (state_nx == S_START);
            seq_busy        <= (state_nx != S_IDLE);
            seq_done        <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_pluse_seq_ctrl.sv
// Bench for pluse_seq_ctrl: builds each sequence's expected per-cycle output
// timeline from the configured words and chosen pulse delays, then drives it.
module tb_pluse_seq_ctrl;

    localparam int W = 38;
    localparam int SHIFT = 8;

    logic        clk_sys = 1'b0;
    logic        seqrst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        seq_go = 1'b0;
    logic        seq_abort = 1'b0;
    logic        pluseinter = 1'b0;
    logic        pluseload, pluseloadchoice, plusestart;
    logic        seq_busy, seq_done, err_timeout;
    logic [15:0] plusedatain, rep_idx;
    logic [2:0]  dbg_state;
    logic [W-1:0] obs_v;

    int total = 0;
    int bad = 0;
    logic [15:0] cfg_m [8];
    logic [15:0] rep_m = '0;
    logic        err_m = 1'b0;
    int dly [16];

    pluse_seq_ctrl #(.TO_SHIFT(SHIFT)) dut (
        .clk_sys(clk_sys), .seqrst(seqrst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .seq_go(seq_go), .seq_abort(seq_abort),
        .pluseinter(pluseinter), .pluseload(pluseload),
        .pluseloadchoice(pluseloadchoice), .plusedatain(plusedatain),
        .plusestart(plusestart), .seq_busy(seq_busy), .seq_done(seq_done),
        .rep_idx(rep_idx), .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    always #5 clk_sys = ~clk_sys;

    assign obs_v = {pluseload, pluseloadchoice, plusedatain, plusestart,
                    seq_busy, seq_done, rep_idx, err_timeout};

    function automatic logic [W-1:0] mk(input logic ld, input logic ch,
                                        input logic [15:0] d, input logic st,
                                        input logic bz, input logic dn,
                                        input logic [15:0] rp, input logic er);
        return {ld, ch, d, st, bz, dn, rp, er};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        seq_go = 1'b0; seq_abort = 1'b0; pluseinter = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk_sys); #1;
        clear_inputs();
        cfg_m[a] = d;
        check("cfgw", obs_v, mk(0, 0, 16'd0, 0, 0, 0, rep_m, err_m));
    endtask

    // abort_at: cycle index to abort in, -1 none, -2 random; rst_at: -1 none
    task automatic run_seq(input int abort_at, input int rst_at);
        logic [W-1:0] eq[$];
        bit           pq[$];
        int eff, lim, rep, d, ab;
        logic [15:0] rv;
        eff = (cfg_m[6] == 16'd0) ? 1 : int'(cfg_m[6]);
        lim = int'(cfg_m[7]) << SHIFT;
        for (int k = 0; k < 6; k++) begin
            eq.push_back(mk(1, k == 0, cfg_m[k], 0, 1, 0, 16'd0, 0));
            pq.push_back(1'b0);
        end
        rep = 0;
        for (int r = 1; r <= eff; r++) begin
            eq.push_back(mk(0, 0, 16'd0, 1, 1, 0, 16'(rep), 0));
            pq.push_back(1'b0);
            d = dly[(r - 1) % 16];
            if (lim != 0 && d > lim) begin
                repeat (lim) begin
                    eq.push_back(mk(0, 0, 16'd0, 0, 1, 0, 16'(rep), 0));
                    pq.push_back(1'b0);
                end
                eq.push_back(mk(0, 0, 16'd0, 0, 0, 0, 16'(rep), 1));
                pq.push_back(1'b0);
                break;
            end
            for (int w = 1; w <= d; w++) begin
                eq.push_back(mk(0, 0, 16'd0, 0, 1, 0, 16'(rep), 0));
                pq.push_back(w == d);
            end
            rep = r;
            if (r == eff) begin
                eq.push_back(mk(0, 0, 16'd0, 0, 1, 1, 16'(rep), 0));
                pq.push_back(1'b0);
                eq.push_back(mk(0, 0, 16'd0, 0, 0, 0, 16'(rep), 0));
                pq.push_back(1'b0);
            end else begin
                repeat (2) begin
                    eq.push_back(mk(0, 0, 16'd0, 0, 1, 0, 16'(rep), 0));
                    pq.push_back(1'b0);
                end
            end
        end
        ab = abort_at;
        if (ab == -2)
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, eq.size() - 2)) : -1;

        seq_go = 1'b1;
        @(posedge clk_sys); #1;
        seq_go = 1'b0;
        check("go", obs_v, eq[0]);
        for (int i = 0; i < eq.size() - 1; i++) begin
            pluseinter = pq[i];
            seq_abort  = (i == ab);
            cfg_we     = 1'($urandom_range(0, 1));
            cfg_addr   = 3'($urandom_range(0, 7));
            cfg_data   = 16'($urandom);
            seq_go     = ($urandom_range(0, 3) == 0);
            if (i == rst_at) begin
                #3;
                seqrst = 1'b0;
                #1;
                check("rst", obs_v, '0);
                clear_inputs();
                for (int k = 0; k < 8; k++) cfg_m[k] = '0;
                rep_m = '0;
                err_m = 1'b0;
                return;
            end
            @(posedge clk_sys); #1;
            if (i == ab) begin
                rv = eq[i][16:1];
                clear_inputs();
                check("abort", obs_v, mk(0, 0, 16'd0, 0, 0, 0, rv, 0));
                rep_m = rv;
                err_m = 1'b0;
                return;
            end
            check($sformatf("seq%0d", i), obs_v, eq[i + 1]);
        end
        clear_inputs();
        rv = eq[eq.size() - 1][16:1];
        rep_m = rv;
        err_m = eq[eq.size() - 1][0];
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++) cfg_m[k] = '0;
        for (int k = 0; k < 16; k++) dly[k] = 2;
        clear_inputs();
        repeat (2) @(posedge clk_sys);
        #1;
        check("reset", obs_v, '0);
        seqrst = 1'b1;
        @(posedge clk_sys); #1;
        check("rel", obs_v, '0);

        // Directed: six distinct words, three repetitions, no timeout
        for (int k = 0; k < 6; k++) cfg_write(3'(k), 16'(17 * (k + 1)));
        cfg_write(3'd6, 16'd3);
        cfg_write(3'd7, 16'd0);
        dly[0] = 3; dly[1] = 1; dly[2] = 5;
        run_seq(-1, -1);

        // Timeout with no train end: 256 WAIT cycles
        cfg_write(3'd7, 16'd1);
        cfg_write(3'd6, 16'd2);
        dly[0] = 300;
        run_seq(-1, -1);

        // Train end in the very cycle the timeout would fire
        cfg_write(3'd6, 16'd1);
        dly[0] = 256;
        run_seq(-1, -1);

        // Abort while word 3 is on the bus, then a clean restart
        cfg_write(3'd7, 16'd0);
        dly[0] = 4;
        run_seq(3, -1);
        run_seq(-1, -1);

        // Repeat count of zero acts as one
        cfg_write(3'd6, 16'd0);
        run_seq(-1, -1);

        // go together with abort in IDLE is ignored
        seq_go = 1'b1; seq_abort = 1'b1;
        @(posedge clk_sys); #1;
        clear_inputs();
        check("goab", obs_v, mk(0, 0, 16'd0, 0, 0, 0, rep_m, err_m));

        // Randomized sequences
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 6; k++) cfg_write(3'(k), 16'($urandom));
            cfg_write(3'd6, 16'($urandom_range(0, 3)));
            cfg_write(3'd7, 16'($urandom_range(0, 1)));
            for (int k = 0; k < 16; k++)
                dly[k] = ($urandom_range(0, 9) == 0) ? 260 : int'($urandom_range(1, 12));
            run_seq(-2, -1);
        end

        // Reset during WAIT of the second repetition, then a run on cleared words
        cfg_write(3'd6, 16'd3);
        cfg_write(3'd7, 16'd0);
        dly[0] = 2; dly[1] = 10; dly[2] = 10;
        run_seq(-1, 14);
        @(posedge clk_sys); #1;
        check("inrst", obs_v, '0);
        seqrst = 1'b1;
        @(posedge clk_sys); #1;
        check("rel2", obs_v, '0);
        dly[0] = 2;
        run_seq(-1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
